// File: rtl/rom_load_pkg.sv
// Region map, ioctl index codes and FIFO entry layout shared by the ROM download router.
package rom_load_pkg;

  typedef enum logic [2:0] {
    RegCpu      = 3'd0,
    RegBg       = 3'd1,
    RegSpr      = 3'd2,
    RegSnd      = 3'd3,
    RegZeroPage = 3'd4
  } region_e;

  localparam int unsigned NUM_REGIONS = 5;

  localparam logic [24:0] CPU_BASE  = 25'h00000;
  localparam logic [24:0] CPU_SIZE  = 25'h0C000;
  localparam logic [24:0] BG_BASE   = 25'h0C000;
  localparam logic [24:0] BG_SIZE   = 25'h02000;
  localparam logic [24:0] SPR_BASE  = 25'h0E000;
  localparam logic [24:0] SPR_SIZE  = 25'h04000;
  localparam logic [24:0] SND_BASE  = 25'h12000;
  localparam logic [24:0] SND_SIZE  = 25'h01000;
  localparam logic [24:0] ZP_BASE   = 25'h13000;
  localparam logic [24:0] ZP_SIZE   = 25'h00100;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef struct packed {
    region_e     region;
    logic [15:0] addr;
    logic [7:0]  data;
  } rom_wr_t;

  localparam int unsigned ROM_WR_W = $bits(rom_wr_t);

  typedef struct packed {
    logic        hit;
    region_e     region;
    logic [15:0] offset;
  } lookup_t;

  function automatic logic [24:0] region_base(input region_e r);
    case (r)
      RegCpu:      return CPU_BASE;
      RegBg:       return BG_BASE;
      RegSpr:      return SPR_BASE;
      RegSnd:      return SND_BASE;
      RegZeroPage: return ZP_BASE;
      default:     return '0;
    endcase
  endfunction

  // A zero size makes undefined encodings unreachable in the lookup.
  function automatic logic [24:0] region_size(input region_e r);
    case (r)
      RegCpu:      return CPU_SIZE;
      RegBg:       return BG_SIZE;
      RegSpr:      return SPR_SIZE;
      RegSnd:      return SND_SIZE;
      RegZeroPage: return ZP_SIZE;
      default:     return '0;
    endcase
  endfunction

  function automatic lookup_t region_lookup(input logic [24:0] addr);
    lookup_t res;
    region_e r;
    res = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      r = region_e'(i[2:0]);
      if (!res.hit && addr >= region_base(r) && (addr - region_base(r)) < region_size(r)) begin
        res.hit    = 1'b1;
        res.region = r;
        res.offset = 16'(addr - region_base(r));
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rom_wr_fifo.sv
// Synchronous FIFO with simultaneous push/pop; a push into a full FIFO is taken only with a pop.
module rom_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 27
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rom_load_router.sv
// ioctl download router: decodes ROM/mod/DIP writes, buffers ROM bytes and sequences board reset.
// Defining ROM_CHECKSUM_EN adds rom_sum, a wrapping sum of ROM bytes accepted during LOAD.
module rom_load_router
  import rom_load_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_wr,
  input  logic        rom_ready,
  output region_e     rom_region,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  mod,
  output logic [63:0] dip_sw,
  output logic        board_reset,
  output logic        load_done,
`ifdef ROM_CHECKSUM_EN
  output logic [15:0] rom_sum,
`endif
  output logic [15:0] drop_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  lookup_t       lookup;
  logic          rom_req, push_req, miss, overflow_evt;
  rom_wr_t       push_word, head_word, out_q;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          out_valid_q, accept;
  logic          wait_q;
  logic [1:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          download_q, start, drained;
  logic          board_reset_q, load_done_q;
  logic [15:0]   drop_q, drop_d;
  logic [7:0]    mod_q;
  logic [63:0]   dip_q;

  assign lookup       = region_lookup(ioctl_addr);
  assign rom_req      = ioctl_wr && (ioctl_index == IDX_ROM);
  assign push_req     = rom_req && lookup.hit;
  assign miss         = rom_req && !lookup.hit;
  assign push_word    = '{region: lookup.region, addr: lookup.offset, data: ioctl_dout};
  assign accept       = out_valid_q && rom_ready;
  assign fifo_pop     = !fifo_empty && (!out_valid_q || rom_ready);
  assign overflow_evt = push_req && fifo_full && !fifo_pop;

  rom_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROM_WR_W)
  ) u_fifo (
    .clk       (clk_sys),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output holding register: refilled from the FIFO head whenever it is empty or being taken.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (fifo_pop) begin
      out_valid_q <= 1'b1;
      out_q       <= head_word;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) wait_q <= 1'b0;
    else       wait_q <= (fifo_count >= CW'(FIFO_DEPTH - 1));
  end

  assign start   = ioctl_download && !download_q && (ioctl_index == IDX_ROM);
  // Drained once the last buffered byte is taken at this edge.
  assign drained = fifo_empty && (!out_valid_q || rom_ready);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: if (!ioctl_download) state_d = StDrain;
      StDrain: begin
        if (start) begin
          state_d = StLoad;
        end else if (drained) begin
          state_d = StHold;
          hold_d  = 8'(HOLD_CYCLES);
        end
      end
      StHold: begin
        if (start)              state_d = StLoad;
        else if (hold_q == '0)  state_d = StIdle;
        else                    hold_d  = hold_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset parks the FSM in a full-length hold so the boards see an extended reset.
  always_ff @(posedge clk_sys) begin
    download_q <= ioctl_download;
    if (reset) begin
      state_q       <= StHold;
      hold_q        <= 8'(HOLD_CYCLES);
      board_reset_q <= 1'b1;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      board_reset_q <= (state_d != StIdle);
      load_done_q   <= (state_q == StHold) && (state_d == StIdle);
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (start) drop_d = '0;
    if ((miss || overflow_evt) && (drop_d != 16'hFFFF)) drop_d = drop_d + 16'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mod_q <= 8'hFF;
      dip_q <= '0;
    end else if (ioctl_wr) begin
      if (ioctl_index == IDX_MOD && ioctl_addr == '0) mod_q <= ioctl_dout;
      if (ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0) begin
        dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state_q != StLoad && state_d == StLoad) begin
      sum_q <= '0;
    end else if (state_q == StLoad && accept) begin
      sum_q <= sum_q + 16'(out_q.data);
    end
  end

  assign rom_sum = sum_q;
`endif

`ifndef SYNTHESIS
  logic overflow_q;

  always_ff @(posedge clk_sys) begin
    if (reset)             overflow_q <= 1'b0;
    else if (overflow_evt) overflow_q <= 1'b1;
  end

  fifo_overflow: assert property (@(posedge clk_sys) disable iff (reset) !overflow_q);
`endif

  assign ioctl_wait  = wait_q;
  assign rom_wr      = out_valid_q;
  assign rom_region  = out_q.region;
  assign rom_addr    = out_q.addr;
  assign rom_data    = out_q.data;
  assign mod         = mod_q;
  assign dip_sw      = dip_q;
  assign board_reset = board_reset_q;
  assign load_done   = load_done_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_rom_load_router.sv
// Randomized scoreboard bench for rom_load_router: a region-table model predicts ROM writes,
// drop counts, mod/DIP state and board reset timing.
module tb_rom_load_router;
  import rom_load_pkg::*;

  localparam int HOLD  = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, ioctl_download, ioctl_wr, rom_ready;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, rom_wr, board_reset, load_done;
  region_e     rom_region;
  logic [15:0] rom_addr, drop_cnt;
  logic [7:0]  rom_data, mod;
  logic [63:0] dip_sw;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] rom_sum;
`endif

  rom_load_router #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_wr         (rom_wr),
    .rom_ready      (rom_ready),
    .rom_region     (rom_region),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .mod            (mod),
    .dip_sw         (dip_sw),
    .board_reset    (board_reset),
    .load_done      (load_done),
`ifdef ROM_CHECKSUM_EN
    .rom_sum        (rom_sum),
`endif
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned base [5] = '{32'h00000, 32'h0C000, 32'h0E000, 32'h12000, 32'h13000};
  int unsigned size [5] = '{32'h0C000, 32'h02000, 32'h04000, 32'h01000, 32'h00100};

  logic [26:0] exp_q[$];
  int          nchk = 0, nerr = 0;
  int          cyc = 0, last_acc = 0;
  int          model_drop = 0;
  logic [7:0]  model_mod = 8'hFF;
  logic [63:0] model_dip = '0;
  bit          stall = 0, rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_lookup(input int unsigned addr, output int unsigned rid,
                                      output int unsigned off);
    rid = 0;
    off = 0;
    for (int i = 0; i < 5; i++) begin
      if (addr >= base[i] && addr < base[i] + size[i]) begin
        rid = i;
        off = addr - base[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [24:0] rand_addr();
    int unsigned r = $urandom_range(9);
    int unsigned i = $urandom_range(4);
    if (r < 6)       return 25'(base[i] + $urandom_range(size[i] - 1));
    else if (r == 6) return 25'(base[i]);
    else if (r == 7) return 25'(base[i] + size[i] - 1);
    else             return 25'($urandom_range(32'h1FFFF, 32'h13100));
  endfunction

  // Issue one ioctl byte, honouring ioctl_wait, and update the reference model.
  task automatic strobe(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    int g = 0;
    int unsigned rid, off;
    while (ioctl_wait && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) chk(1'b0, "wait_timeout", 64'(g), 64'd0);
    if (idx == 8'd0) begin
      if (model_lookup(int'(addr), rid, off)) exp_q.push_back({3'(rid), 16'(off), data});
      else if (model_drop < 65535) model_drop++;
    end else if (idx == 8'd1 && addr == 0) begin
      model_mod = data;
    end else if (idx == 8'd254 && addr < 8) begin
      model_dip[8*int'(addr) +: 8] = data;
    end
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      tick();
      g++;
    end
    chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (board_reset !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rom_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rom_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  // Monitor: pops the scoreboard on each accepted write and checks stall stability.
  initial begin
    bit          prev_stall = 0;
    logic [26:0] prev_word = '0, cur, e;
    forever begin
      @(negedge clk);
      cur = {rom_region, rom_addr, rom_data};
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk(rom_wr === 1'b1 && cur === prev_word, "stall_hold", {rom_wr, cur},
              {1'b1, prev_word});
        end
        if (rom_wr && rom_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_wr", 64'(cur), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(cur === e, "rom_word", 64'(cur), 64'(e));
          end
          last_acc = cyc + 1;
        end
        prev_stall = rom_wr && !rom_ready;
        prev_word  = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit wait_seen;
    logic [24:0] bnd [4] = '{25'h0BFFF, 25'h0C000, 25'h130FF, 25'h13100};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) tick();
    chk(board_reset === 1'b1, "rst_board_reset", 64'(board_reset), 64'd1);
    chk(rom_wr === 1'b0, "rst_rom_wr", 64'(rom_wr), 64'd0);
    chk(mod === model_mod, "rst_mod", 64'(mod), 64'(model_mod));
    chk(dip_sw === model_dip, "rst_dip", dip_sw, model_dip);
    chk(drop_cnt === 16'd0, "rst_drop", 64'(drop_cnt), 64'd0);
    chk(ioctl_wait === 1'b0 && load_done === 1'b0, "rst_wait_done",
        {ioctl_wait, load_done}, 64'd0);
    reset = 1'b0;
    wait_release(n);
    chk(n == HOLD + 1, "por_hold_len", 64'(n), 64'(HOLD + 1));
    chk(load_done === 1'b1, "por_load_done", 64'(load_done), 64'd1);
    tick();
    chk(load_done === 1'b0, "load_done_width", 64'(load_done), 64'd0);

    // ROM download: first-byte latency into region BG
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    model_drop = 0;
    chk(board_reset === 1'b1, "load_board_reset", 64'(board_reset), 64'd1);
    strobe(8'd0, 25'h0C005, 8'h5A);
    chk(rom_wr === 1'b0, "latency_early", 64'(rom_wr), 64'd0);
    tick();
    chk(rom_wr === 1'b1 && rom_region == RegBg && rom_addr == 16'h0005 && rom_data == 8'h5A,
        "latency_2", {rom_wr, rom_region, rom_addr, rom_data}, {1'b1, RegBg, 16'h0005, 8'h5A});
    drain();

    strobe(8'd0, 25'h1F000, 8'h11);
    chk(drop_cnt == 16'(model_drop), "miss_drop", 64'(drop_cnt), 64'(model_drop));
    foreach (bnd[i]) strobe(8'd0, bnd[i], 8'(i + 8'h30));
    drain();
    chk(drop_cnt == 16'(model_drop), "boundary_drop", 64'(drop_cnt), 64'(model_drop));

    // Consumer stall across a back-to-back burst
    stall = 1;
    repeat (2) tick();
    wait_seen = 0;
    fork
      begin
        repeat (20) begin
          tick();
          if (ioctl_wait) wait_seen = 1;
        end
        stall = 0;
      end
      for (int i = 0; i < 10; i++) strobe(8'd0, rand_addr(), 8'($urandom));
    join
    chk(wait_seen, "wait_asserted", 64'(wait_seen), 64'd1);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      strobe(8'd0, rand_addr(), 8'($urandom));
      repeat ($urandom_range(2)) tick();
    end
    chk(drop_cnt == 16'(model_drop), "random_drop", 64'(drop_cnt), 64'(model_drop));
    rand_ready = 0;
    drain();

    // End of download with two bytes in flight
    strobe(8'd0, 25'h12345, 8'hC3);
    strobe(8'd0, 25'h00010, 8'h3C);
    ioctl_download = 1'b0;
    wait_release(n);
    chk(cyc - last_acc == HOLD + 1, "drain_to_release", 64'(cyc - last_acc), 64'(HOLD + 1));
    chk(load_done === 1'b1, "drain_load_done", 64'(load_done), 64'd1);
    chk(exp_q.size() == 0, "drain_all_delivered", 64'(exp_q.size()), 64'd0);

    // mod and DIP downloads stay in IDLE
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    strobe(8'd1, 25'd0, 8'h02);
    chk(mod === model_mod, "mod_load", 64'(mod), 64'(model_mod));
    strobe(8'd1, 25'd5, 8'h77);
    chk(mod === model_mod, "mod_ignore", 64'(mod), 64'(model_mod));
    ioctl_download = 1'b0;
    tick();
    ioctl_index = 8'd254; ioctl_download = 1'b1;
    tick();
    strobe(8'd254, 25'd3, 8'hA5);
    chk(dip_sw[31:24] === 8'hA5, "dip_byte3", 64'(dip_sw[31:24]), 64'hA5);
    strobe(8'd254, 25'd8, 8'hEE);
    for (int i = 0; i < 6; i++) strobe(8'd254, 25'($urandom_range(7)), 8'($urandom));
    chk(dip_sw === model_dip, "dip_all", dip_sw, model_dip);
    chk(board_reset === 1'b0, "aux_board_reset", 64'(board_reset), 64'd0);
    ioctl_download = 1'b0;
    tick();

    // New ROM download clears drop_cnt; then reset lands with bytes queued
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    model_drop = 0;
    chk(drop_cnt == 16'(model_drop), "drop_cleared", 64'(drop_cnt), 64'(model_drop));
    stall = 1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) strobe(8'd0, 25'(base[i] + 32'h10), 8'(8'h90 + i));
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    exp_q.delete();
    model_mod = 8'hFF; model_dip = '0; model_drop = 0;
    chk(rom_wr === 1'b0, "midrst_rom_wr", 64'(rom_wr), 64'd0);
    chk(mod === model_mod, "midrst_mod", 64'(mod), 64'(model_mod));
    chk(dip_sw === model_dip, "midrst_dip", dip_sw, model_dip);
    chk(drop_cnt == 16'(model_drop), "midrst_drop", 64'(drop_cnt), 64'(model_drop));
    chk(board_reset === 1'b1, "midrst_board_reset", 64'(board_reset), 64'd1);
    stall = 0;
    tick();
    reset = 1'b0;
    wait_release(n);
    chk(n == HOLD + 1, "midrst_hold_len", 64'(n), 64'(HOLD + 1));
    repeat (5) tick();
    chk(rom_wr === 1'b0, "midrst_fifo_empty", 64'(rom_wr), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
